// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction-fetch stage feeding decode. Owns the program counter, drives
//   the word address into an asynchronous instruction memory, and buffers each
//   fetched word with its PC in a 2-entry FIFO that decode drains through a
//   valid/ready handshake. Branch, jump and jump-register requests redirect
//   the PC and flush any buffered (now stale) fetches.
//
// Ports
//   clk, reset            single clock, synchronous active-high reset
//   imem_addr  (out 32)   byte address to instruction memory (the PC register)
//   imem_rdata (in  32)   instruction word at imem_addr, same cycle
//   halt       (in  1)    suppress new fetches; buffer still drains
//   out_valid/out_ready   handshake toward decode
//   out_instr, out_pc, out_pc_plus4 (out 32)  FIFO head contents
//   br_taken, br_base, br_offset              branch redirect request
//   jump, jump_index                          J-format redirect request
//   jr, jr_target                             register-target redirect request
//   misalign_err (out 1)  sticky: some redirect target had bits [1:0] != 0

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        halt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    input  logic        br_taken,
    input  logic [31:0] br_base,
    input  logic [15:0] br_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic        misalign_err
);

    logic [31:0] pc;
    logic [31:0] fifo_pc    [0:1];
    logic [31:0] fifo_instr [0:1];
    logic        head;
    logic        tail;
    logic [1:0]  count;

    logic        redirect;
    logic        pop;
    logic        push;
    logic [31:0] br_target;
    logic [31:0] target;

    assign redirect = jr | jump | br_taken;
    assign out_valid = (count != 2'd0);
    assign pop = out_valid & out_ready;
    // A full buffer can still accept a fetch when decode pops the head in the
    // same cycle, which is what keeps the stream bubble-free after a stall.
    assign push = !halt && !redirect && ((count != 2'd2) || pop);

    // Signed word offset scaled to bytes; carry out of bit 31 is dropped.
    assign br_target = br_base + {{14{br_offset[15]}}, br_offset, 2'b00};

    // jr outranks jump, which outranks a taken branch.
    always_comb begin
        target = br_target;
        if (jr) begin
            target = jr_target;
        end else if (jump) begin
            target = {br_base[31:28], jump_index, 2'b00};
        end
    end

    // PC, pointers, occupancy and the sticky misalignment flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= RESET_PC;
            head         <= 1'b0;
            tail         <= 1'b0;
            count        <= 2'd0;
            misalign_err <= 1'b0;
        end else if (redirect) begin
            // Any pop this cycle was accepted by decode; the entry is simply
            // discarded together with everything else in the buffer.
            pc    <= {target[31:2], 2'b00};
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
            if (target[1:0] != 2'b00) begin
                misalign_err <= 1'b1;
            end
        end else begin
            if (push) begin
                pc   <= pc + 32'd4;
                tail <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Buffer storage needs no reset: the head is only exposed while count != 0.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            fifo_pc[tail]    <= pc;
            fifo_instr[tail] <= imem_rdata;
        end
    end

    assign imem_addr    = pc;
    assign out_instr    = out_valid ? fifo_instr[head] : 32'd0;
    assign out_pc       = out_valid ? fifo_pc[head] : 32'd0;
    assign out_pc_plus4 = out_valid ? (fifo_pc[head] + 32'd4) : 32'd0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//   Self-checking bench for fetch_unit. A queue-based reference model tracks
//   the PC, the buffered {pc, instr} entries and the sticky error flag; one
//   process compares every DUT output against it on each falling edge. A
//   directed prologue pins the model with literal expectations, followed by
//   a randomized phase.

module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        halt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        br_taken;
    logic [31:0] br_base;
    logic [15:0] br_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_target;
    logic        misalign_err;

    int checks = 0;
    int failures = 0;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .halt         (halt),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_pc_plus4 (out_pc_plus4),
        .br_taken     (br_taken),
        .br_base      (br_base),
        .br_offset    (br_offset),
        .jump         (jump),
        .jump_index   (jump_index),
        .jr           (jr),
        .jr_target    (jr_target),
        .misalign_err (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: each word encodes its own address.
    assign imem_rdata = 32'h1000_0000 + imem_addr;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      mq[$];
    logic [31:0] mpc;
    logic        merr;
    bit          live = 0;

    always @(posedge clk) begin
        logic [31:0] tgt;
        logic signed [31:0] soff;
        if (reset) begin
            mq.delete();
            mpc  = RESET_PC;
            merr = 1'b0;
            live = 1;
        end else if (live) begin
            if (jr || jump || br_taken) begin
                soff = $signed(br_offset);
                if (jr)
                    tgt = jr_target;
                else if (jump)
                    tgt = {br_base[31:28], jump_index, 2'b00};
                else
                    tgt = br_base + soff * 4;
                if (tgt[1:0] != 2'b00)
                    merr = 1'b1;
                mq.delete();
                mpc = {tgt[31:2], 2'b00};
            end else begin
                if (mq.size() != 0 && out_ready)
                    void'(mq.pop_front());
                if (!halt && mq.size() < 2) begin
                    mq.push_back('{pc: mpc, instr: 32'h1000_0000 + mpc});
                    mpc = mpc + 32'd4;
                end
            end
        end
    end

    task automatic checkValue(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkOutput();
        checkValue("imem_addr", imem_addr, mpc);
        checkValue("out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
        checkValue("misalign_err", {31'd0, misalign_err}, {31'd0, merr});
        if (mq.size() != 0) begin
            checkValue("out_pc", out_pc, mq[0].pc);
            checkValue("out_instr", out_instr, mq[0].instr);
            checkValue("out_pc_plus4", out_pc_plus4, mq[0].pc + 32'd4);
        end
    endtask

    always @(negedge clk) begin
        if (live)
            checkOutput();
    end

    // Drive one cycle of inputs, then advance just past the next rising edge.
    task automatic applyStimulus(input logic rst, input logic hlt, input logic rdy,
                                 input logic br, input logic [31:0] base,
                                 input logic [15:0] off, input logic jmp,
                                 input logic [25:0] idx, input logic j,
                                 input logic [31:0] jt);
        reset      = rst;
        halt       = hlt;
        out_ready  = rdy;
        br_taken   = br;
        br_base    = base;
        br_offset  = off;
        jump       = jmp;
        jump_index = idx;
        jr         = j;
        jr_target  = jt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy, input logic hlt);
        applyStimulus(1'b0, hlt, rdy, 1'b0, 32'd0, 16'd0, 1'b0, 26'd0, 1'b0, 32'd0);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0, 1'b0, 26'd0, 1'b0, 32'd0);
    endtask

    initial begin
        // Reset state
        doReset();
        doReset();
        checkValue("rst imem_addr", imem_addr, 32'h0);
        checkValue("rst out_valid", {31'd0, out_valid}, 32'd0);
        checkValue("rst out_instr", out_instr, 32'h0);
        checkValue("rst out_pc", out_pc, 32'h0);
        checkValue("rst out_pc_plus4", out_pc_plus4, 32'h0);
        checkValue("rst misalign_err", {31'd0, misalign_err}, 32'd0);

        // Streaming, one instruction per cycle
        idle(1'b1, 1'b0);
        checkValue("stream first valid", {31'd0, out_valid}, 32'd1);
        checkValue("stream first instr", out_instr, 32'h1000_0000);
        for (int i = 1; i < 5; i++) begin
            idle(1'b1, 1'b0);
            checkValue("stream out_pc", out_pc, 32'(4 * i));
            checkValue("stream out_instr", out_instr, 32'h1000_0000 + 32'(4 * i));
        end

        // Backpressure
        doReset();
        for (int i = 0; i < 5; i++)
            idle(1'b0, 1'b0);
        checkValue("bp held out_pc", out_pc, 32'h0);
        checkValue("bp imem stall", imem_addr, 32'h8);
        idle(1'b1, 1'b0);
        checkValue("bp release 1", out_pc, 32'h4);
        idle(1'b1, 1'b0);
        checkValue("bp release 2", out_pc, 32'h8);

        // Branch with negative offset: 0x10 - 8 = 0x8
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 16'hFFFE, 1'b0, 26'd0, 1'b0, 32'd0);
        checkValue("br imem_addr", imem_addr, 32'h8);
        checkValue("br flushed", {31'd0, out_valid}, 32'd0);
        idle(1'b1, 1'b0);
        checkValue("br out_pc", out_pc, 32'h8);

        // All three redirects at once: jr wins
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 16'h0004, 1'b1, 26'h3, 1'b1, 32'h40);
        checkValue("prio imem_addr", imem_addr, 32'h40);
        idle(1'b1, 1'b0);
        checkValue("prio out_pc", out_pc, 32'h40);

        // Jump target keeps the region bits of br_base
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'hF000_0000, 16'd0, 1'b1, 26'h1, 1'b0, 32'd0);
        checkValue("jump imem_addr", imem_addr, 32'hF000_0004);

        // PC wrap at 2^32
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 16'd0, 1'b0, 26'd0, 1'b1, 32'hFFFF_FFFC);
        idle(1'b1, 1'b0);
        checkValue("wrap imem_addr", imem_addr, 32'h0);
        checkValue("wrap out_pc", out_pc, 32'hFFFF_FFFC);
        checkValue("wrap out_pc_plus4", out_pc_plus4, 32'h0);

        // Misaligned jr target, then halt drains the buffer
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 16'd0, 1'b0, 26'd0, 1'b1, 32'h42);
        checkValue("mis imem_addr", imem_addr, 32'h40);
        checkValue("mis err", {31'd0, misalign_err}, 32'd1);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        checkValue("mis err held", {31'd0, misalign_err}, 32'd1);
        checkValue("halt pre out_pc", out_pc, 32'h40);
        idle(1'b1, 1'b1);
        checkValue("halt drain out_pc", out_pc, 32'h44);
        checkValue("halt pc frozen", imem_addr, 32'h48);
        idle(1'b1, 1'b1);
        checkValue("halt drained", {31'd0, out_valid}, 32'd0);
        idle(1'b1, 1'b1);
        checkValue("halt pc still", imem_addr, 32'h48);

        // Reset with a full buffer and a redirect pending
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0, 1'b0, 26'd0, 1'b1, 32'h100);
        checkValue("midrst out_valid", {31'd0, out_valid}, 32'd0);
        checkValue("midrst imem_addr", imem_addr, RESET_PC);
        checkValue("midrst err", {31'd0, misalign_err}, 32'd0);
        idle(1'b1, 1'b0);
        checkValue("midrst restart", out_pc, RESET_PC);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] jt;
            jt = $urandom;
            if ($urandom_range(7) != 0)
                jt[1:0] = 2'b00;
            applyStimulus($urandom_range(255) == 0,
                          $urandom_range(4) == 0,
                          $urandom_range(2) != 0,
                          $urandom_range(11) == 0,
                          $urandom,
                          16'($urandom),
                          $urandom_range(15) == 0,
                          26'($urandom),
                          $urandom_range(15) == 0,
                          jt);
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage sitting directly upstream of decode in the single-cycle datapath. It owns the program counter, drives the word address into instruction memory (`im`, asynchronous read), and captures each fetched word together with its PC into a 2-entry buffer. Decode pulls from the buffer with a valid/ready handshake. The block redirects the PC on branch, jump and jump-register requests and flushes stale fetches.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `imem_addr`  out  32  byte address to instruction memory; always equals the PC register.
- `imem_rdata`  in  32  instruction word at `imem_addr`, valid in the same cycle (combinational read).
- `halt`  in  1  when 1, no new fetch is pushed; the buffer still drains.
- `out_valid`  out  1  buffer head is valid.
- `out_ready`  in  1  decode accepts the head this cycle.
- `out_instr`  out  32  head instruction word.
- `out_pc`  out  32  head instruction address.
- `out_pc_plus4`  out  32  `out_pc + 4`, modulo 2^32.
- `br_taken`  in  1  redirect to a branch target.
- `br_base`  in  32  PC+4 of the branch instruction.
- `br_offset`  in  16  signed word offset.
- `jump`  in  1  redirect to `{br_base[31:28], jump_index, 2'b00}`.
- `jump_index`  in  26  J-format target field.
- `jr`  in  1  redirect to `jr_target`.
- `jr_target`  in  32  register-sourced target.
- `misalign_err`  out  1  sticky flag: a redirect target had bits [1:0] != 0.

## Operation
- State: PC (32 bits), a 2-entry FIFO of {pc, instr} with head/tail pointers and a 2-bit count (0..2), and `misalign_err`.
- **Handshake:** a pop occurs when `out_valid & out_ready`. `out_*` are driven from the FIFO head and are stable while `out_valid=1` and `out_ready=0`.
- **Fetch:** a fetch occurs when `!halt`, there is no redirect, and (count<2, or count==2 with a pop this cycle). A fetch pushes {PC, `imem_rdata`} and sets PC <= PC+4, wrapping at 2^32.
- **Simultaneous push and pop:** count is unchanged. Entry order is strict FIFO.
- **Redirect:** a redirect occurs when any of `jr`, `jump`, `br_taken` is 1.
  - Priority is `jr` > `jump` > `br_taken`.
  - Branch target = `br_base + (sign_extend(br_offset) << 2)`, computed in 32 bits with the carry dropped.
  - On redirect: the FIFO is cleared (count=0), PC <= target with bits [1:0] forced to 00, and no push occurs that cycle.
  - A pop coinciding with a redirect still counts as accepted by decode; the entry is then discarded along with the rest.
- **Misaligned target:** if the selected target has bits [1:0] != 0, `misalign_err` is set to 1 and held until reset.
- **Halt:** PC is held. Buffered entries remain poppable.
- **Halt and redirect together:** the redirect still updates PC and flushes the buffer.

## Timing
- **Reset (sync, takes priority over everything):**
  - PC=`RESET_PC`, count=0, pointers=0.
  - `out_valid`=0, `misalign_err`=0.
  - `out_instr`, `out_pc` and `out_pc_plus4` read 0.
- **Reset mid-operation:** all buffered entries and any pending redirect are lost. Fetch restarts at `RESET_PC`.
- **After reset:**
  - Cycle 0 (first cycle with reset=0): `imem_addr`=`RESET_PC`, `out_valid`=0.
  - Cycle 1: `out_valid`=1 with `out_pc`=`RESET_PC`.
- **Throughput:** 1 instruction/cycle while `out_ready`=1 and there is no halt or redirect.
- **Backpressure:**
  - With `out_ready`=0 the FIFO fills after 2 fetches, then PC stalls.
  - When `out_ready` returns to 1, no bubble is inserted, because push and pop happen in the same cycle.
- **Redirect latency:** redirect asserted in cycle N gives `imem_addr`=target in cycle N+1 and `out_valid`=1 with `out_pc`=target in cycle N+2.
- **`out_valid`:** equals (count != 0).
- **Combinational paths:** `imem_addr` has no combinational path from any input.

## Test plan
- **Reset and streaming:** `RESET_PC`=0x0, imem returns 0x1000_0000+addr, `out_ready`=1 -> from cycle 1, `out_pc` = 0x0, 0x4, 0x8, … with `out_instr` = 0x1000_0000, 0x1000_0004, …, one per cycle; `out_pc_plus4` = `out_pc`+4.
- **Backpressure:** `out_ready`=0 for 5 cycles after the first valid -> `out_pc` held at 0x0, `imem_addr` stalls at 0x8, FIFO holds {0x0, 0x4}. Then `out_ready`=1 -> 0x0, 0x4, 0x8 delivered in consecutive cycles.
- **Branch:** `br_taken`=1, `br_base`=0x0000_0010, `br_offset`=16'hFFFE -> next `imem_addr`=0x0000_0008, FIFO flushed, next delivered `out_pc`=0x8.
- **Priority and wrap:**
  - `jr`=1 (`jr_target`=0x40), `jump`=1 and `br_taken`=1 asserted together -> target 0x40.
  - `jump` with `br_base`=0xF000_0000 and `jump_index`=26'h1 -> target 0xF000_0004.
  - PC=0xFFFF_FFFC fetch -> next PC 0x0.
- **Misalign and halt:** `jr_target`=0x42 -> PC=0x40, `misalign_err`=1 and held. Then `halt`=1 -> PC frozen and 2 buffered entries drain, after which `out_valid`=0.
- **Reset mid-stream:** assert `reset` with count=2 and a redirect pending -> next cycle `out_valid`=0, PC=`RESET_PC`, `misalign_err`=0.
